// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared definitions for the serial ripple-borrow subtractor: FSM state
// encoding, default geometry and the digit-counter width helper.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DIGIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    // Width of the digit counter: clog2 of the digit count, never below one
    // bit so a single-digit configuration still has a legal vector.
    function automatic int unsigned cnt_width(input int unsigned width,
                                              input int unsigned digit);
        int unsigned w;
        w = $clog2(width / digit);
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_ripple_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bi with borrow-out bo.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Multi-cycle subtractor: diff = a - b - b_in, DIGIT bits per clock through a
// short ripple-borrow chain, borrow registered between digits. Valid/ready
// handshakes on both sides. Optional feature macro: SERIAL_SUB_OVERFLOW_EN
// adds the ovf output (signed overflow of the subtraction).
module serial_ripple_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DIGIT = DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             busy
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_ripple_subtractor: DIGIT must divide WIDTH exactly");
    end

    sub_state_e         state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   diff_q;
    logic [CW-1:0]      cnt_q;
    logic               borrow_q;
    logic               last_q;      // all digits processed, finishing cycle next
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               b_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic               a_msb_q;
    logic               b_msb_q;
    logic               ovf_q;
`endif

    logic [DIGIT:0]       chain_s;
    logic [DIGIT-1:0]     dig_s;
    logic [WIDTH+DIGIT-1:0] diff_cat_s;
    logic [WIDTH-1:0]     diff_d;

    // Ripple-borrow chain for the current digit, seeded by the stored borrow.
    assign chain_s[0] = borrow_q;
    for (genvar i = 0; i < DIGIT; i++) begin : g_fs
        full_subtractor u_fs (
            .x  (a_q[i]),
            .y  (b_q[i]),
            .bi (chain_s[i]),
            .d  (dig_s[i]),
            .bo (chain_s[i+1])
        );
    end

    // New digit enters at the MSB end so the first digit lands in the LSBs.
    assign diff_cat_s = {dig_s, diff_q};
    assign diff_d     = diff_cat_s[WIDTH+DIGIT-1:DIGIT];

    // Control FSM, operand/result shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            diff_q      <= {WIDTH{1'b0}};
            cnt_q       <= {CW{1'b0}};
            borrow_q    <= 1'b0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            b_out_q     <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        borrow_q   <= b_in;
                        cnt_q      <= {CW{1'b0}};
                        last_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        a_msb_q    <= a[WIDTH-1];
                        b_msb_q    <= b[WIDTH-1];
                        ovf_q      <= 1'b0;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (last_q) begin
                        // Final borrow and full difference are settled: publish.
                        b_out_q     <= borrow_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        ovf_q       <= (a_msb_q != b_msb_q) &&
                                       (diff_q[WIDTH-1] != a_msb_q);
`endif
                    end else begin
                        a_q      <= a_q >> DIGIT;
                        b_q      <= b_q >> DIGIT;
                        diff_q   <= diff_d;
                        borrow_q <= chain_s[DIGIT];
                        cnt_q    <= cnt_q + CW'(1);
                        if (cnt_q == LAST_DIG) begin
                            last_q <= 1'b1;
                        end else begin
                            last_q <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign diff      = diff_q;
    assign b_out     = b_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign ovf       = ovf_q;
`endif

endmodule
